// File: rtl/sad_disparity_sequencer.sv
// sad_disparity_sequencer
// Sequences an external registered adder to accumulate the sum of absolute
// differences of one pixel window for each disparity candidate. It keeps the
// lowest SAD and reports it over a valid/ready result port. When two
// disparities give the same SAD, the lower disparity wins.
// Optional feature: define SAD_SEQ_SATURATE_EN to clamp the accumulator to all
// ones on adder carry-out. When it is undefined, the accumulator wraps modulo
// 2^SUM_BITS.
module sad_disparity_sequencer #(
  parameter int PIX_BITS  = 8,
  parameter int WIN_PIX   = 9,
  parameter int MAX_DISP  = 16,
  parameter int SUM_BITS  = 16,
  parameter int DISP_BITS = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  output logic                 busy,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [PIX_BITS-1:0]  pix_left,
  input  logic [PIX_BITS-1:0]  pix_right,
  output logic [SUM_BITS-1:0]  add_in1,
  output logic [SUM_BITS-1:0]  add_in2,
  input  logic [SUM_BITS:0]    add_sum,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DISP_BITS-1:0] res_disp,
  output logic [SUM_BITS-1:0]  res_sad
);

  localparam int CNT_W = (WIN_PIX > 1) ? $clog2(WIN_PIX) : 1;
  localparam logic [CNT_W-1:0]     LAST_PIX  = CNT_W'(WIN_PIX - 1);
  localparam logic [DISP_BITS-1:0] LAST_DISP = DISP_BITS'(MAX_DISP - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ADD   = 3'd2,
    LATCH = 3'd3,
    CMP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic [SUM_BITS-1:0]   acc;
  logic [SUM_BITS-1:0]   best_sad;
  logic [DISP_BITS-1:0]  best_disp;
  logic [DISP_BITS-1:0]  disp;
  logic [CNT_W-1:0]      pix_cnt;
  logic                  last_pix;
  logic                  last_disp;

  // |left - right| formed as a signed PIX_BITS+1 difference, then zero-extended
  function automatic logic [SUM_BITS-1:0] abs_diff(input logic [PIX_BITS-1:0] l,
                                                   input logic [PIX_BITS-1:0] r);
    logic signed [PIX_BITS:0] d;
    logic        [PIX_BITS:0] m;
    d = $signed({1'b0, l}) - $signed({1'b0, r});
    m = (d < 0) ? $unsigned(-d) : $unsigned(d);
    return SUM_BITS'(m);
  endfunction

  // Accumulator update from the adder result: clamp or wrap on carry-out
  function automatic logic [SUM_BITS-1:0] next_acc(input logic [SUM_BITS:0] s);
`ifdef SAD_SEQ_SATURATE_EN
    return s[SUM_BITS] ? {SUM_BITS{1'b1}} : s[SUM_BITS-1:0];
`else
    return s[SUM_BITS-1:0];
`endif
  endfunction

  assign last_pix  = (pix_cnt == LAST_PIX);
  assign last_disp = (disp == LAST_DISP);

  // The result port shows zero outside DONE, so reset and idle values stay quiet
  assign res_disp = res_valid ? best_disp : '0;
  assign res_sad  = res_valid ? best_sad  : '0;

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_nx  = state;
    busy      = (state != IDLE);
    pix_ready = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = FETCH;
      FETCH: begin
        pix_ready = 1'b1;
        if (pix_valid) state_nx = ADD;
      end
      ADD:   state_nx = LATCH;
      LATCH: state_nx = last_pix ? CMP : FETCH;
      CMP:   state_nx = last_disp ? DONE : FETCH;
      DONE:  begin
        res_valid = 1'b1;
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Accumulator, counters, best-so-far tracking and the adder operand registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc       <= '0;
      best_sad  <= '1;
      best_disp <= '0;
      disp      <= '0;
      pix_cnt   <= '0;
      add_in1   <= '0;
      add_in2   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            pix_cnt   <= '0;
            disp      <= '0;
            best_disp <= '0;
            best_sad  <= '1;
          end
        end
        FETCH: begin
          if (pix_valid) begin
            add_in1 <= acc;
            add_in2 <= abs_diff(pix_left, pix_right);
          end
        end
        LATCH: begin
          acc <= next_acc(add_sum);
          if (!last_pix) pix_cnt <= pix_cnt + CNT_W'(1);
        end
        CMP: begin
          if (acc < best_sad) begin
            best_sad  <= acc;
            best_disp <= disp;
          end
          if (!last_disp) begin
            disp    <= disp + DISP_BITS'(1);
            acc     <= '0;
            pix_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_disparity_sequencer.sv
// Testbench for sad_disparity_sequencer: default-size instance plus a narrow
// 8-bit accumulator instance for the overflow case, each with a registered
// adder model and a result scoreboard.
module tb_sad_disparity_sequencer;

  localparam int PIX_BITS  = 8;
  localparam int WIN_PIX   = 9;
  localparam int MAX_DISP  = 16;
  localparam int SUM_BITS  = 16;
  localparam int DISP_BITS = 5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                 reset_n, start, pix_valid, res_ready;
  logic [PIX_BITS-1:0]  pix_left, pix_right;
  logic                 busy, pix_ready, res_valid;
  logic [SUM_BITS-1:0]  add_in1, add_in2, res_sad;
  logic [SUM_BITS:0]    add_sum;
  logic [DISP_BITS-1:0] res_disp;

  logic       s_start, s_pix_valid, s_res_ready;
  logic [7:0] s_l, s_r;
  logic       s_busy, s_pix_ready, s_res_valid;
  logic [7:0] s_add_in1, s_add_in2, s_res_sad;
  logic [8:0] s_add_sum;
  logic [4:0] s_res_disp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [DISP_BITS-1:0] d;
    logic [SUM_BITS-1:0]  s;
  } res_t;
  res_t sb[$];

  sad_disparity_sequencer #(
    .PIX_BITS(PIX_BITS), .WIN_PIX(WIN_PIX), .MAX_DISP(MAX_DISP),
    .SUM_BITS(SUM_BITS), .DISP_BITS(DISP_BITS)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .busy(busy),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_left(pix_left), .pix_right(pix_right),
    .add_in1(add_in1), .add_in2(add_in2), .add_sum(add_sum),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_disp(res_disp), .res_sad(res_sad)
  );

  sad_disparity_sequencer #(
    .PIX_BITS(8), .WIN_PIX(2), .MAX_DISP(1), .SUM_BITS(8), .DISP_BITS(5)
  ) dut_small (
    .clock(clock), .reset_n(reset_n), .start(s_start), .busy(s_busy),
    .pix_valid(s_pix_valid), .pix_ready(s_pix_ready),
    .pix_left(s_l), .pix_right(s_r),
    .add_in1(s_add_in1), .add_in2(s_add_in2), .add_sum(s_add_sum),
    .res_valid(s_res_valid), .res_ready(s_res_ready),
    .res_disp(s_res_disp), .res_sad(s_res_sad)
  );

  // Registered adders with one cycle of latency
  always_ff @(posedge clock) begin
    add_sum   <= {1'b0, add_in1} + {1'b0, add_in2};
    s_add_sum <= {1'b0, s_add_in1} + {1'b0, s_add_in2};
    cyc       <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $display("FAIL %s: observed timeout expected DUT response", tag);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "bounded wait expired");
  endtask

  function automatic void pix_gen(input int mode, input int d, input int p,
                                  output logic [7:0] l, output logic [7:0] r);
    case (mode)
      0: begin
        if (d == 3)          begin l = 8'd50; r = 8'd50; end
        else if (p % 2 == 1) begin l = 8'd40; r = 8'd50; end
        else                 begin l = 8'd60; r = 8'd50; end
      end
      1: begin
        if (p % 2 == 1) begin l = 8'd20; r = 8'd25; end
        else            begin l = 8'd25; r = 8'd20; end
      end
      default: begin
        l = 8'((d * 29 + p * 13) % 256);
        r = 8'((d * 17 + p * 7 + 3) % 256);
      end
    endcase
  endfunction

  function automatic res_t model(input int mode);
    res_t        res;
    logic [7:0]  l, r;
    logic [15:0] acc;
    logic [16:0] s;
    int          a;
    res.d = '0;
    res.s = 16'hFFFF;
    for (int d = 0; d < MAX_DISP; d++) begin
      acc = '0;
      for (int p = 0; p < WIN_PIX; p++) begin
        pix_gen(mode, d, p, l, r);
        a = (int'(l) > int'(r)) ? int'(l) - int'(r) : int'(r) - int'(l);
        s = {1'b0, acc} + 17'(a);
`ifdef SAD_SEQ_SATURATE_EN
        acc = s[16] ? 16'hFFFF : s[15:0];
`else
        acc = s[15:0];
`endif
      end
      if (acc < res.s) begin
        res.s = acc;
        res.d = 5'(d);
      end
    end
    return res;
  endfunction

  // Runs one full window; returns the cycle index where res_valid first rose
  task automatic run_window(input int mode, input bit toggle, input bit pulse_start,
                            output int first_cyc);
    int         e0, n;
    bit         ph, done;
    logic [7:0] l, r;
    sb.push_back(model(mode));
    ph = 1'b1;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    e0 = cyc;
    for (int d = 0; d < MAX_DISP; d++) begin
      for (int p = 0; p < WIN_PIX; p++) begin
        pix_gen(mode, d, p, l, r);
        pix_left  = l;
        pix_right = r;
        if (pulse_start && d == 2 && p == 0) begin
          pix_valid = 1'b0;
          n = 0;
          while (!pix_ready) begin
            @(negedge clock);
            n++;
            if (n > 50) timeout_fail("wait_fetch");
          end
          start = 1'b1;
          chk("busy_at_ignored_start", 32'(busy), 32'd1);
          @(negedge clock);
          start = 1'b0;
          chk("still_fetch_after_start", 32'(pix_ready), 32'd1);
        end
        done = 1'b0;
        n = 0;
        while (!done) begin
          pix_valid = toggle ? ph : 1'b1;
          ph = ~ph;
          done = pix_valid && pix_ready;
          @(negedge clock);
          n++;
          if (n > 100) timeout_fail("pixel_accept");
        end
      end
    end
    pix_valid = 1'b0;
    n = 0;
    while (!res_valid) begin
      @(negedge clock);
      n++;
      if (n > 2000) timeout_fail("res_valid_wait");
    end
    first_cyc = cyc - e0 + 1;
  endtask

  // Called at a negedge with res_valid high; holds res_ready low for 'hold' cycles
  task automatic collect(input int hold);
    res_t                 e;
    logic [DISP_BITS-1:0] d0;
    logic [SUM_BITS-1:0]  s0;
    d0 = res_disp;
    s0 = res_sad;
    res_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_disp", 32'(res_disp), 32'(d0));
      chk("hold_sad", 32'(res_sad), 32'(s0));
      @(negedge clock);
    end
    res_ready = 1'b1;
    chk("sb_nonempty", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("res_valid", 32'(res_valid), 32'd1);
      chk("res_disp", 32'(res_disp), 32'(e.d));
      chk("res_sad", 32'(res_sad), 32'(e.s));
    end
    @(negedge clock);
    res_ready = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_res_valid", 32'(res_valid), 32'd0);
  endtask

  initial begin
    int fc, n;
    reset_n = 1'b0; start = 1'b0; pix_valid = 1'b0; res_ready = 1'b0;
    pix_left = '0; pix_right = '0;
    s_start = 1'b0; s_pix_valid = 1'b0; s_res_ready = 1'b0; s_l = '0; s_r = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_sad", 32'(res_sad), 32'd0);
    chk("rst_res_disp", 32'(res_disp), 32'd0);
    chk("rst_add_in1", 32'(add_in1), 32'd0);
    chk("rst_add_in2", 32'(add_in2), 32'd0);
    reset_n = 1'b1;

    // Disparity 3 matches exactly; continuous pixels give the nominal latency
    run_window(0, 1'b0, 1'b0, fc);
    chk("latency", 32'(fc), 32'd449);
    chk("exact_disp", 32'(res_disp), 32'd3);
    chk("exact_sad", 32'(res_sad), 32'd0);
    collect(0);

    // All disparities tie; a start pulse inside disparity 2 must be ignored
    run_window(1, 1'b0, 1'b1, fc);
    chk("tie_sad", 32'(res_sad), 32'd45);
    chk("tie_disp", 32'(res_disp), 32'd0);
    collect(0);

    // Reset during ADD abandons the window
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    pix_left = 8'd77; pix_right = 8'd10; pix_valid = 1'b1;
    chk("abort_fetch_ready", 32'(pix_ready), 32'd1);
    @(negedge clock);
    pix_valid = 1'b0;
    chk("abort_add_in1", 32'(add_in1), 32'd0);
    chk("abort_add_in2", 32'(add_in2), 32'd67);
    chk("abort_add_not_ready", 32'(pix_ready), 32'd0);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_pix_ready", 32'(pix_ready), 32'd0);
    chk("abort_add_in2_cleared", 32'(add_in2), 32'd0);
    repeat (3) @(negedge clock);
    chk("abort_no_result", 32'(res_valid), 32'd0);

    // Backpressure on both ports after the abandoned window
    run_window(2, 1'b1, 1'b0, fc);
    collect(5);

    // Narrow accumulator: 255 + 255 overflows 8 bits
    @(negedge clock);
    s_start = 1'b1;
    @(negedge clock);
    s_start = 1'b0;
    s_l = 8'd255; s_r = 8'd0; s_pix_valid = 1'b1;
    n = 0;
    while (!s_res_valid) begin
      @(negedge clock);
      n++;
      if (n > 50) timeout_fail("small_res_valid_wait");
    end
    s_pix_valid = 1'b0;
`ifdef SAD_SEQ_SATURATE_EN
    chk("small_sad", 32'(s_res_sad), 32'd255);
`else
    chk("small_sad", 32'(s_res_sad), 32'd254);
`endif
    chk("small_disp", 32'(s_res_disp), 32'd0);
    s_res_ready = 1'b1;
    @(negedge clock);
    s_res_ready = 1'b0;
    chk("small_idle", 32'(s_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sad_disparity_sequencer.md
# sad_disparity_sequencer

Controller that sequences the shared registered `Adder` datapath to compute a sum of absolute differences (SAD) per window for disparities 0..MAX_DISP-1. It selects the winning disparity, lowest SAD with lowest disparity on ties, and returns it over a valid/ready result port. It sits between the window pixel fetcher and the depth-map writer. It owns the adder inputs exclusively while busy.

## Interface
- `PIX_BITS`, 8, pixel width
- `WIN_PIX`, 9, pixels per window (≥1)
- `MAX_DISP`, 16, disparity candidates (≥1)
- `SUM_BITS`, 16, accumulator/adder operand width
- `DISP_BITS`, 5, disparity index width (must hold MAX_DISP-1)

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low.
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  synchronous active-low reset
- `start`  in  1  begin a window; sampled only in IDLE
- `busy`  out  1  state != IDLE
- `pix_valid`  in  1  pixel pair available
- `pix_ready`  out  1  sequencer accepts pixel pair
- `pix_left`  in  PIX_BITS  left pixel
- `pix_right`  in  PIX_BITS  right pixel (already shifted by current disparity upstream)
- `add_in1`  out  SUM_BITS  adder operand: accumulator
- `add_in2`  out  SUM_BITS  adder operand: zero-extended |left−right|
- `add_sum`  in  SUM_BITS+1  registered adder result, 1-cycle latency
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts result
- `res_disp`  out  DISP_BITS  winning disparity
- `res_sad`  out  SUM_BITS  winning SAD

## Operation
- Pixels are consumed disparity-major: all WIN_PIX pairs for disparity 0, then disparity 1, and so on.
- States:
  - IDLE: on `start`, clear acc, pix_cnt, disp and best_disp; set best_sad to all ones; go to FETCH.
  - FETCH: `pix_ready`=1. On `pix_valid`, register `add_in1`=acc and `add_in2`=|pix_left−pix_right|, then go to ADD. Otherwise stay in FETCH.
  - ADD: one cycle while the adder registers its operands; go to LATCH.
  - LATCH: acc ← `add_sum` (width rule below). If pix_cnt==WIN_PIX-1, go to CMP. Otherwise increment pix_cnt and go to FETCH.
  - CMP: if acc < best_sad (strict), set best_sad ← acc and best_disp ← disp. If disp==MAX_DISP-1, go to DONE. Otherwise increment disp, clear acc and pix_cnt, and go to FETCH.
  - DONE: `res_valid`=1, with `res_disp`/`res_sad` driven from best_*. Hold these until `res_ready`, then go to IDLE.
- Width rule: |diff| is computed at PIX_BITS+1 signed and zero-extended to SUM_BITS. Overflow handling is set by the macro (see Configuration).
- `start` outside IDLE is ignored.
- `pix_valid` outside FETCH is ignored (no transfer).
- `reset_n`=0 at any edge, including mid-window, forces IDLE on that edge and abandons the partial window with no result emitted.

## Timing
- Reset values:
  - outputs: `busy`=0, `pix_ready`=0, `res_valid`=0, `add_in1`=0, `add_in2`=0, `res_disp`=0, `res_sad`=0
  - internal: acc=0, best_sad=all ones
- 3 cycles per pixel (FETCH/ADD/LATCH) with `pix_valid` held high; each FETCH cycle with `pix_valid` low adds one cycle.
- Per disparity: 3·WIN_PIX+1 cycles.
- Latency: `start` sampled at edge 0, `res_valid` first high in cycle 1+MAX_DISP·(3·WIN_PIX+1), which is 449 at defaults.
- `res_valid` and result are stable until the handshake cycle. IDLE is entered on the edge where `res_valid`&&`res_ready`. `start` is accepted in the following cycle at the earliest.
- `add_in1`/`add_in2` are registered and change only on the FETCH acceptance edge.

## Configuration
- `SAD_SEQ_SATURATE_EN` defined: if `add_sum[SUM_BITS]`=1, acc ← all ones and stays saturated for the rest of that disparity.
- `SAD_SEQ_SATURATE_EN` undefined: acc ← `add_sum[SUM_BITS-1:0]`; the carry is discarded (modulo 2^SUM_BITS).

## Test plan
- Reset → assert `reset_n`=0 for 2 cycles → `busy`=0, `pix_ready`=0, `res_valid`=0, `res_sad`=0, `res_disp`=0.
- Defaults; |L−R|=10 for every pixel except disparity 3, which uses L=R=50; `pix_valid`=1 continuously → `res_valid` first high in cycle 449 with `res_disp`=3, `res_sad`=0.
- Tie: |L−R|=5 everywhere → `res_sad`=45, `res_disp`=0.
- Backpressure: `pix_valid` toggling 1/0 every cycle, and `res_ready` low for 5 cycles after `res_valid` → correct result; `res_valid`/`res_disp`/`res_sad` held unchanged for those 5 cycles; IDLE one edge after `res_ready`=1.
- SUM_BITS=8, WIN_PIX=2, MAX_DISP=1, L=255, R=0 → `res_sad`=255 with macro, 254 without.
- Mid-operation: `start` pulsed in FETCH of disparity 2 → ignored. Then `reset_n`=0 during ADD → IDLE next cycle, no `res_valid`; a new `start` then completes normally.
